writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered multdiv write entries; power of two, at least 2.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 ctrl_reset  input  1  asynchronous, active-low reset.
REQ-004 pipe_valid  input  1  pipeline writeback request this cycle; always accepted.
REQ-005 pipe_reg  input  5  pipeline destination register.
REQ-006 pipe_data  input  32  pipeline write data.
REQ-007 md_valid  input  1  multdiv result request; transfers when md_valid and md_ready are both high.
REQ-008 md_reg  input  5  multdiv destination register.
REQ-009 md_data  input  32  multdiv result data.
REQ-010 md_ready  output  1  queue can accept a multdiv entry.
REQ-011 ctrl_writeEnable  output  1  register file write strobe (registered).
REQ-012 ctrl_writeReg  output  5  register file write index (registered).
REQ-013 data_writeReg  output  32  register file write data (registered).
REQ-014 pending  output  32  bit k set while a valid queued entry targets register k.
REQ-015 count  output  clog2(DEPTH)+1  number of occupied queue slots, including killed slots.

Function
REQ-016 Pipeline priority: when pipe_valid is high and pipe_reg is not 0, the next cycle presents ctrl_writeEnable=1, ctrl_writeReg=pipe_reg, data_writeReg=pipe_data (latency 1).
REQ-017 Drain: when pipe_valid is low and the queue is not empty, the head is popped; if the head is valid, the next cycle presents its write, and if it is killed, ctrl_writeEnable is 0.
REQ-018 Idle: when no write is issued, ctrl_writeEnable is 0 the next cycle, and ctrl_writeReg/data_writeReg hold their previous values.
REQ-019 md_ready equals NOT full, computed from start-of-cycle occupancy; a pop in the same cycle does not free a slot for that cycle's push.
REQ-020 Simultaneous push and pop: both occur, and count is unchanged.
REQ-021 Register 0: requests to register 0 are accepted but never enqueued or written, and pending[0] is always 0.
REQ-022 Ordering: a pipe write to register r kills every queued entry targeting r in the same cycle; killed entries still occupy slots until popped.
REQ-023 Same-cycle conflict: if md_reg equals pipe_reg and both are valid, the md entry is accepted and discarded, not enqueued.
REQ-024 Same-register multdiv pushes: entries are written in FIFO order, so the last write wins.
REQ-025 Wrap-around: head and tail pointers wrap modulo DEPTH, and full/empty are distinguished by count.

Reset
REQ-026 While ctrl_reset is low: queue flushed, count=0, pending=0, md_ready=1, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
REQ-027 Reset asserted mid-operation discards all queued and in-flight writes, with no partial write presented after release.
REQ-028 First accepted request is taken on the first rising clock edge after ctrl_reset is released.

Configuration
REQ-029 Macro WBQ_FWD_EN adds the input lookup_reg(5) and the outputs lookup_hit(1) and lookup_data(32).
REQ-030 With WBQ_FWD_EN defined, lookup outputs are combinational: lookup_hit=1 and lookup_data = the youngest valid queued entry targeting lookup_reg, or the registered output write if it targets lookup_reg; register 0 never hits.
REQ-031 Without WBQ_FWD_EN, the lookup ports are absent and no comparison logic is generated.

Structure
REQ-032 Shared package wb_pkg holds REG_W=5, DATA_W=32, the default DEPTH, and the entry typedef {valid, reg, data}.
REQ-033 Storage and pointer logic go in sub-module wb_fifo (push, pop, kill-by-register, full, empty, count); writeback_queue holds arbitration and output registers.

Verification
REQ-034 Reset, then pipe_valid with reg 5 and data 0x1234 -> the next cycle shows ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234.
REQ-035 Four md pushes to regs 1..4 with pipe_valid held high -> md_ready=0 and count=4; then pipe_valid low -> regs 1..4 written on 4 consecutive cycles and pending returns to 0.
REQ-036 Queue holds reg 7 = 0xAAAA, then pipe writes reg 7 = 0xBBBB -> pending[7] clears, only 0xBBBB is written to reg 7, and the killed pop gives ctrl_writeEnable=0.
REQ-037 Same cycle: md reg 9 and pipe reg 9 -> only the pipe data is written, and count is unchanged.
REQ-038 Writes to reg 0 from both sources -> ctrl_writeEnable stays 0 and count stays 0.
REQ-039 ctrl_reset asserted with 3 entries queued -> count=0, pending=0, and no writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, default depth and queue entry type for the writeback queue.
package wb_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Bus bundle for writeback_queue; lookup signals exist only when WBQ_FWD_EN is defined.
interface writeback_queue_if #(
  parameter int unsigned DEPTH = wb_pkg::WB_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                        pipe_valid;
  logic [wb_pkg::REG_W-1:0]    pipe_reg;
  logic [wb_pkg::DATA_W-1:0]   pipe_data;
  logic                        md_valid;
  logic [wb_pkg::REG_W-1:0]    md_reg;
  logic [wb_pkg::DATA_W-1:0]   md_data;
  logic                        md_ready;
  logic                        ctrl_writeEnable;
  logic [wb_pkg::REG_W-1:0]    ctrl_writeReg;
  logic [wb_pkg::DATA_W-1:0]   data_writeReg;
  logic [wb_pkg::NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]            count;
`ifdef WBQ_FWD_EN
  logic [wb_pkg::REG_W-1:0]    lookup_reg;
  logic                        lookup_hit;
  logic [wb_pkg::DATA_W-1:0]   lookup_data;
`endif

  modport master (
    output pipe_valid, pipe_reg, pipe_data, md_valid, md_reg, md_data,
    input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, count
`ifdef WBQ_FWD_EN
    , output lookup_reg
    , input  lookup_hit, lookup_data
`endif
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data, md_valid, md_reg, md_data,
    output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, count
`ifdef WBQ_FWD_EN
    , input  lookup_reg
    , output lookup_hit, lookup_data
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular entry store with kill-by-register; unoccupied slots always hold valid=0.
// WBQ_FWD_EN adds a youngest-match lookup over the queued entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  i_push,
  input  wb_entry_t             i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [REG_W-1:0]      i_kill_reg,
  output wb_entry_t             o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [NUM_REGS-1:0]   o_pending
`ifdef WBQ_FWD_EN
  ,
  input  logic [REG_W-1:0]      i_lookup_reg,
  output logic                  o_lookup_hit,
  output logic [DATA_W-1:0]     o_lookup_data
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [NUM_REGS-1:0] w_pending;

  // Kill first, then pop/push so a slot being written takes the new entry.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_mem[i].valid && (r_mem[i].wreg == i_kill_reg))
          r_mem[i].valid <= 1'b0;
      end
      if (i_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      if (i_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].valid) w_pending[r_mem[i].wreg] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

`ifdef WBQ_FWD_EN
  // Walk oldest to youngest so the last match is the youngest entry.
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[r_head + PTR_W'(i)].valid &&
          (r_mem[r_head + PTR_W'(i)].wreg == i_lookup_reg)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_mem[r_head + PTR_W'(i)].data;
      end
    end
  end
`endif

  assign o_head    = r_mem[r_head];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pending = w_pending;

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback arbiter: pipeline writes win, multdiv results queue behind them.
// Optional macro WBQ_FWD_EN adds a combinational forwarding lookup.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input logic          clock,
  input logic          ctrl_reset,
  writeback_queue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              w_pipe_wr;
  logic              w_md_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  wb_entry_t         w_push_entry;
  wb_entry_t         w_head;
  logic [CNT_W-1:0]  w_count;
  logic [NUM_REGS-1:0] w_pending;

  logic              r_we;
  logic [REG_W-1:0]  r_wreg;
  logic [DATA_W-1:0] r_wdata;

  assign w_pipe_wr = bus.pipe_valid && (bus.pipe_reg != '0);
  // Same-register md results are superseded by the pipeline write this cycle.
  assign w_md_push = bus.md_valid && !w_full && (bus.md_reg != '0) &&
                     !(bus.pipe_valid && (bus.md_reg == bus.pipe_reg));
  assign w_pop     = !bus.pipe_valid && !w_empty;

  assign w_push_entry = '{valid: 1'b1, wreg: bus.md_reg, data: bus.md_data};

`ifdef WBQ_FWD_EN
  logic              w_q_hit;
  logic [DATA_W-1:0] w_q_data;
  logic              w_out_hit;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .i_push       (w_md_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill       (w_pipe_wr),
    .i_kill_reg   (bus.pipe_reg),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_pending    (w_pending)
`ifdef WBQ_FWD_EN
    ,
    .i_lookup_reg (bus.lookup_reg),
    .o_lookup_hit (w_q_hit),
    .o_lookup_data(w_q_data)
`endif
  );

  // Killed heads pop silently and leave the last write index/data in place.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_pipe_wr) begin
      r_we    <= 1'b1;
      r_wreg  <= bus.pipe_reg;
      r_wdata <= bus.pipe_data;
    end else if (w_pop && w_head.valid) begin
      r_we    <= 1'b1;
      r_wreg  <= w_head.wreg;
      r_wdata <= w_head.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

`ifdef WBQ_FWD_EN
  // Queued entries are younger than the write currently on the output.
  assign w_out_hit       = r_we && (r_wreg == bus.lookup_reg) && (bus.lookup_reg != '0);
  assign bus.lookup_hit  = w_q_hit || w_out_hit;
  assign bus.lookup_data = w_q_hit ? w_q_data : r_wdata;
`endif

  assign bus.md_ready         = !w_full;
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_wreg;
  assign bus.data_writeReg    = r_wdata;
  assign bus.pending          = w_pending;
  assign bus.count            = w_count;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: driver queues expected writes, a negedge monitor checks them.
module tb_writeback_queue;

  logic clock = 1'b0;
  logic ctrl_reset;

  always #5 clock = ~clock;

  writeback_queue_if #(.DEPTH(4)) bus ();

  writeback_queue #(.DEPTH(4)) u_dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.pipe_valid = pv;
    bus.pipe_reg   = pr;
    bus.pipe_data  = pd;
    bus.md_valid   = mv;
    bus.md_reg     = mr;
    bus.md_data    = md;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge clock) begin
    if (ctrl_reset === 1'b1 && bus.ctrl_writeEnable === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h, required no write",
                 bus.ctrl_writeReg, bus.data_writeReg);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.ctrl_writeReg, bus.data_writeReg} !== mon_exp) begin
          n_fail++;
          $display("FAIL write_data: got reg %0d data 0x%0h, required reg %0d data 0x%0h",
                   bus.ctrl_writeReg, bus.data_writeReg, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
`ifdef WBQ_FWD_EN
    bus.lookup_reg = '0;
`endif
    ctrl_reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();

    // Reset state
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst_pending",  bus.pending, 32'd0);
    chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
    chk("rst_we",       32'(bus.ctrl_writeEnable), 32'd0);
    chk("rst_wreg",     32'(bus.ctrl_writeReg), 32'd0);
    chk("rst_wdata",    bus.data_writeReg, 32'd0);

    // Single pipe write right after release, then idle hold
    ctrl_reset = 1'b1;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'h1234);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_we",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("idle_wreg",  32'(bus.ctrl_writeReg), 32'd5);
    chk("idle_wdata", bus.data_writeReg, 32'h1234);

    // Fill the queue while the pipe keeps writing reg 31
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd31, 32'h3100 + 32'(i), 1'b1, 5'(i), 32'h1000 + 32'(i));
      expect_wr(5'd31, 32'h3100 + 32'(i));
      tick();
    end
    chk("full_count",    32'(bus.count), 32'd4);
    chk("full_md_ready", 32'(bus.md_ready), 32'd0);
    chk("full_pending",  bus.pending, 32'h0000_001E);
    drive(1'b1, 5'd31, 32'h3105, 1'b1, 5'd6, 32'h6666);
    expect_wr(5'd31, 32'h3105);
    tick();
    chk("full_reject_count",   32'(bus.count), 32'd4);
    chk("full_reject_pending", bus.pending, 32'h0000_001E);

    // Drain, with a push in the same cycle as a pop (wraps the tail)
    expect_wr(5'd1, 32'h1001);
    expect_wr(5'd2, 32'h1002);
    expect_wr(5'd3, 32'h1003);
    expect_wr(5'd4, 32'h1004);
    expect_wr(5'd8, 32'h8888);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("drain1_count",    32'(bus.count), 32'd3);
    chk("drain1_md_ready", 32'(bus.md_ready), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h8888);
    tick();
    chk("pushpop_count",   32'(bus.count), 32'd3);
    chk("pushpop_pending", bus.pending, 32'h0000_0118);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();
    chk("drained_count",   32'(bus.count), 32'd0);
    chk("drained_pending", bus.pending, 32'd0);
    tick();

    // Pipe write kills a queued entry for the same register
    drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAAAA);
    tick();
    chk("kill_pre_pending", bus.pending, 32'h0000_0080);
    chk("kill_pre_count",   32'(bus.count), 32'd1);
    drive(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd7, 32'hBBBB);
    tick();
    chk("kill_pending", bus.pending, 32'd0);
    chk("kill_count",   32'(bus.count), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("killed_pop_we",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("killed_pop_count", 32'(bus.count), 32'd0);

    // Same-cycle conflict on reg 9
    drive(1'b1, 5'd9, 32'h5555, 1'b1, 5'd9, 32'h9999);
    expect_wr(5'd9, 32'h5555);
    tick();
    chk("conflict_count",   32'(bus.count), 32'd0);
    chk("conflict_pending", bus.pending, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // Register 0 from both sources
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    tick();
    chk("r0_both_we",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("r0_both_count", 32'(bus.count), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF);
    tick();
    chk("r0_md_we",       32'(bus.ctrl_writeEnable), 32'd0);
    chk("r0_md_count",    32'(bus.count), 32'd0);
    chk("r0_md_pending",  bus.pending, 32'd0);

    // Two md pushes to reg 12: FIFO order, last one wins
    drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1);
    tick();
    drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd12, 32'h2);
    tick();
    chk("samereg_count",   32'(bus.count), 32'd2);
    chk("samereg_pending", bus.pending, 32'h0000_1000);
    expect_wr(5'd12, 32'h1);
    expect_wr(5'd12, 32'h2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();
    chk("samereg_final_data", bus.data_writeReg, 32'h2);
    tick();

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 32'h0, 1'b1, 5'(13 + i), 32'hC000 + 32'(i));
      tick();
    end
    chk("prereset_count", 32'(bus.count), 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ctrl_reset = 1'b0;
    #2;
    chk("midrst_count",    32'(bus.count), 32'd0);
    chk("midrst_pending",  bus.pending, 32'd0);
    chk("midrst_md_ready", 32'(bus.md_ready), 32'd1);
    chk("midrst_we",       32'(bus.ctrl_writeEnable), 32'd0);
    repeat (2) tick();
    ctrl_reset = 1'b1;
    repeat (4) tick();
    chk("postrst_we",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("postrst_count", 32'(bus.count), 32'd0);

    // Every expected write must have appeared within a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
